// File: rtl/tx_slot_gate_pkg.sv
// Shared constants, FSM encoding and small helpers for the TX slot gate.
package tx_slot_gate_pkg;

   localparam int C_M_AXIS_DATA_WIDTH  = 256;
   localparam int C_S_AXIS_DATA_WIDTH  = C_M_AXIS_DATA_WIDTH;
   localparam int C_M_AXIS_TUSER_WIDTH = 128;
   localparam int C_S_AXIS_TUSER_WIDTH = C_M_AXIS_TUSER_WIDTH;
   localparam int C_SLOT_CNT_WIDTH     = 16;

   localparam int BYTES_PER_BEAT = 32;
   localparam int BEAT_SHIFT     = $clog2(BYTES_PER_BEAT);

   // Packet length field inside tuser.
   localparam int LEN_LSB = 0;
   localparam int LEN_MSB = 15;
   localparam int LEN_W   = LEN_MSB - LEN_LSB + 1;

   localparam int STAT_W = 32;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SEND = 1'b1;

   typedef logic [C_SLOT_CNT_WIDTH-1:0] slot_cnt_t;
   typedef logic [C_SLOT_CNT_WIDTH:0]   slot_rem_t;
   typedef logic [LEN_W:0]              beats_t;
   typedef logic [STAT_W-1:0]           stat_t;

   localparam slot_cnt_t SLOT_ONE   = slot_cnt_t'(1);
   localparam beats_t    BEAT_ROUND = beats_t'(BYTES_PER_BEAT - 1);
   localparam beats_t    ONE_BEAT   = beats_t'(1);
   localparam stat_t     STAT_ONE   = stat_t'(1);

   // Widened by one bit so a 65535-byte length cannot overflow the round-up.
   function automatic beats_t len_to_beats(input logic [LEN_W-1:0] len_bytes);
      beats_t rounded;
      rounded = ({1'b0, len_bytes} + BEAT_ROUND) >> BEAT_SHIFT;
      return (len_bytes == '0) ? ONE_BEAT : rounded;
   endfunction

   function automatic stat_t stat_inc(input stat_t value);
      return (value == '1) ? value : value + STAT_ONE;
   endfunction

endpackage

// File: rtl/tx_slot_gate_if.sv
// Packet stream bus between the TX stage, the slot gate and the output queues.
interface tx_slot_gate_if #(
   parameter int DATA_WIDTH  = tx_slot_gate_pkg::C_S_AXIS_DATA_WIDTH,
   parameter int TUSER_WIDTH = tx_slot_gate_pkg::C_S_AXIS_TUSER_WIDTH
);
   logic [DATA_WIDTH-1:0]   tdata;
   logic [DATA_WIDTH/8-1:0] tstrb;
   logic [TUSER_WIDTH-1:0]  tuser;
   logic                    tvalid;
   logic                    tlast;
   logic                    tready;

   modport master (
      output tdata,
      output tstrb,
      output tuser,
      output tvalid,
      output tlast,
      input  tready
   );

   modport slave (
      input  tdata,
      input  tstrb,
      input  tuser,
      input  tvalid,
      input  tlast,
      output tready
   );
endinterface

// File: rtl/tx_slot_timer.sv
// Free-running slot counter with guard-window indicator, remaining-cycle count
// and wrap strobe for the TX slot gate.
module tx_slot_timer
   import tx_slot_gate_pkg::*;
(
   input  logic      axi_aclk,
   input  logic      axi_aresetn,
   input  slot_cnt_t slot_len,
   input  slot_cnt_t guard_len,
   output logic      slot_open,
   output slot_rem_t remaining,
   output logic      wrap
);

   slot_cnt_t count;
   slot_cnt_t count_nxt;
   logic      at_end;

   // ">=" rather than "==" so a shrinking slot_len cannot strand the counter.
   always_comb begin
      at_end    = (slot_len != '0) && (count >= (slot_len - SLOT_ONE));
      count_nxt = count + SLOT_ONE;
      if (slot_len == '0 || at_end) begin
         count_nxt = '0;
      end
      wrap      = at_end;
      remaining = '0;
      if (count < slot_len) begin
         remaining = {1'b0, slot_len} - {1'b0, count};
      end
   end

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         count     <= '0;
         slot_open <= 1'b0;
      end else begin
         count     <= count_nxt;
         slot_open <= (slot_len != '0) && (guard_len <= count_nxt);
      end
   end

endmodule

// File: rtl/tx_slot_gate.sv
// Gates packets from the TX stage into per-slot transmit windows; a packet is
// only released when it fits in what remains of the open window.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | no packet in flight; head beat held until it is eligible
//   SEND    | packet in flight; stream passes straight through until tlast
module tx_slot_gate
   import tx_slot_gate_pkg::*;
(
   input  logic           axi_aclk,
   input  logic           axi_aresetn,
   tx_slot_gate_if.slave  s_axis,
   tx_slot_gate_if.master m_axis,
   input  logic           cfg_enable,
   input  slot_cnt_t      cfg_slot_len,
   input  slot_cnt_t      cfg_guard_len,
   output logic           slot_open,
   output stat_t          stat_pkts_sent,
   output stat_t          stat_pkts_deferred,
   output stat_t          stat_overruns
);

   logic [0:0] state;

   slot_rem_t slot_remaining;
   logic      slot_wrap;

   beats_t head_beats;
   logic   head_fits;
   logic   head_eligible;
   logic   head_blocked;
   logic   beat_xfer;
   logic   last_xfer;

   logic defer_flag;
   logic overrun_flag;

   logic [C_M_AXIS_DATA_WIDTH-1:0]  pass_tdata;
   logic [C_M_AXIS_TUSER_WIDTH-1:0] pass_tuser;

   tx_slot_timer u_timer (
      .axi_aclk    (axi_aclk),
      .axi_aresetn (axi_aresetn),
      .slot_len    (cfg_slot_len),
      .guard_len   (cfg_guard_len),
      .slot_open   (slot_open),
      .remaining   (slot_remaining),
      .wrap        (slot_wrap)
   );

   // Data and sideband always flow through; only the handshake is gated.
   assign pass_tdata    = s_axis.tdata;
   assign pass_tuser    = s_axis.tuser;
   assign m_axis.tdata  = pass_tdata;
   assign m_axis.tuser  = pass_tuser;
   assign m_axis.tstrb  = s_axis.tstrb;
   assign m_axis.tlast  = s_axis.tlast;
   assign m_axis.tvalid = (state == ST_SEND) && s_axis.tvalid;
   assign s_axis.tready = (state == ST_SEND) && m_axis.tready;

   always_comb begin
      head_beats    = len_to_beats(s_axis.tuser[LEN_MSB:LEN_LSB]);
      head_fits     = slot_open && (head_beats < slot_remaining);
      head_eligible = (state == ST_IDLE) && s_axis.tvalid && (!cfg_enable || head_fits);
      head_blocked  = (state == ST_IDLE) && s_axis.tvalid && !head_eligible;
      beat_xfer     = (state == ST_SEND) && s_axis.tvalid && m_axis.tready;
      last_xfer     = beat_xfer && s_axis.tlast;
   end

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (head_eligible) state <= ST_SEND;
            ST_SEND: if (last_xfer)     state <= ST_IDLE;
            default:                    state <= ST_IDLE;
         endcase
      end
   end

   // Deferrals are counted on the first blocked cycle so a head that never
   // becomes eligible is still visible in the stats.
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         defer_flag         <= 1'b0;
         stat_pkts_deferred <= '0;
      end else begin
         if (head_blocked && !defer_flag) begin
            defer_flag         <= 1'b1;
            stat_pkts_deferred <= stat_inc(stat_pkts_deferred);
         end else if (head_eligible) begin
            defer_flag <= 1'b0;
         end
      end
   end

   // A wrap coinciding with the closing tlast still marks that packet.
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         overrun_flag   <= 1'b0;
         stat_overruns  <= '0;
         stat_pkts_sent <= '0;
      end else begin
         if (last_xfer) begin
            stat_pkts_sent <= stat_inc(stat_pkts_sent);
            overrun_flag   <= 1'b0;
            if (overrun_flag || slot_wrap) begin
               stat_overruns <= stat_inc(stat_overruns);
            end
         end else if ((state == ST_SEND) && slot_wrap) begin
            overrun_flag <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_tx_slot_gate.sv
// Scenario bench for tx_slot_gate: beats are scoreboarded per packet and
// slot timing is checked against a bench-side model of the slot counter.
module tb_tx_slot_gate;

   logic        axi_aclk    = 1'b0;
   logic        axi_aresetn = 1'b0;
   logic        cfg_enable  = 1'b0;
   logic [15:0] cfg_slot_len  = 16'd0;
   logic [15:0] cfg_guard_len = 16'd0;
   logic        slot_open;
   logic [31:0] stat_pkts_sent;
   logic [31:0] stat_pkts_deferred;
   logic [31:0] stat_overruns;

   tx_slot_gate_if s_if ();
   tx_slot_gate_if m_if ();

   tx_slot_gate dut (
      .axi_aclk           (axi_aclk),
      .axi_aresetn        (axi_aresetn),
      .s_axis             (s_if),
      .m_axis             (m_if),
      .cfg_enable         (cfg_enable),
      .cfg_slot_len       (cfg_slot_len),
      .cfg_guard_len      (cfg_guard_len),
      .slot_open          (slot_open),
      .stat_pkts_sent     (stat_pkts_sent),
      .stat_pkts_deferred (stat_pkts_deferred),
      .stat_overruns      (stat_overruns)
   );

   always #5 axi_aclk = ~axi_aclk;

   typedef struct packed {
      logic [31:0] tag;
      logic        last;
   } exp_beat_t;

   exp_beat_t exp_q[$];
   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int mcnt     = 0;

   always @(posedge axi_aclk) cyc <= cyc + 1;

   // Reference slot counter: 0..slot_len-1, held at 0 for slot_len==0.
   always @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn)                          mcnt <= 0;
      else if (cfg_slot_len == 16'd0)            mcnt <= 0;
      else if (mcnt >= int'(cfg_slot_len) - 1)   mcnt <= 0;
      else                                       mcnt <= mcnt + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic drive_beat(input logic [15:0] tag, input int idx, input int nbeats, input int len);
      s_if.tdata        = '0;
      s_if.tdata[31:0]  = {tag, 16'(idx)};
      s_if.tstrb        = '1;
      s_if.tuser        = '0;
      s_if.tuser[15:0]  = 16'(len);
      s_if.tlast        = (idx == nbeats - 1);
      s_if.tvalid       = 1'b1;
   endtask

   task automatic do_reset(input logic en, input int slot_len, input int guard_len);
      s_if.tvalid   = 1'b0;
      s_if.tlast    = 1'b0;
      m_if.tready   = 1'b1;
      cfg_enable    = en;
      cfg_slot_len  = 16'(slot_len);
      cfg_guard_len = 16'(guard_len);
      @(posedge axi_aclk); #1;
      axi_aresetn = 1'b0;
      repeat (3) @(posedge axi_aclk);
      #1;
      axi_aresetn = 1'b1;
   endtask

   task automatic wait_count(input int n);
      for (int i = 0; i < 400 && mcnt != n; i++) begin
         @(posedge axi_aclk); #1;
      end
      if (mcnt != n) begin
         failures++;
         $display("FAIL wait_count: count=%0d required=%0d", mcnt, n);
      end
   endtask

   // Drives one packet; expected beats go to the scoreboard up front and are
   // popped as the DUT presents them on the master side.
   task automatic send_pkt(input logic [15:0] tag, input int len, input int stall_after,
                           input int stall_cycles, output int first_cnt,
                           output int first_cyc, output int last_cyc);
      int nbeats, sent, waited, stall_left;
      bit stalled;
      exp_beat_t e;
      nbeats = (len == 0) ? 1 : (len + 31) / 32;
      for (int b = 0; b < nbeats; b++) begin
         e.tag  = {tag, 16'(b)};
         e.last = (b == nbeats - 1);
         exp_q.push_back(e);
      end
      sent = 0; waited = 0; stall_left = 0; stalled = 0;
      first_cnt = -1; first_cyc = -1; last_cyc = -1;
      drive_beat(tag, 0, nbeats, len);
      while (sent < nbeats && waited < 600) begin
         @(negedge axi_aclk);
         if (m_if.tvalid && m_if.tready) begin
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL beat_extra: got tag=%h with empty scoreboard", m_if.tdata[31:0]);
            end else begin
               e = exp_q.pop_front();
               if (m_if.tdata[31:0] !== e.tag || m_if.tlast !== e.last || m_if.tuser[15:0] !== 16'(len)) begin
                  failures++;
                  $display("FAIL beat: got tag=%h last=%b len=%0d expected tag=%h last=%b len=%0d",
                           m_if.tdata[31:0], m_if.tlast, m_if.tuser[15:0], e.tag, e.last, len);
               end
            end
            if (sent == 0) begin
               first_cnt = mcnt;
               first_cyc = cyc;
            end
            last_cyc = cyc;
            sent++;
         end
         waited++;
         @(posedge axi_aclk); #1;
         if (stall_left > 0) begin
            stall_left--;
            if (stall_left == 0) m_if.tready = 1'b1;
         end else if (!stalled && stall_cycles > 0 && sent == stall_after) begin
            m_if.tready = 1'b0;
            stall_left  = stall_cycles;
            stalled     = 1'b1;
         end
         if (sent < nbeats) drive_beat(tag, sent, nbeats, len);
         else               s_if.tvalid = 1'b0;
      end
      if (sent < nbeats) begin
         checks++;
         failures++;
         $display("FAIL pkt_timeout: tag=%h beats=%0d required=%0d", tag, sent, nbeats);
         s_if.tvalid = 1'b0;
         m_if.tready = 1'b1;
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      cfg_enable    = 1'b0;
      cfg_slot_len  = 16'd100;
      cfg_guard_len = 16'd0;
      m_if.tready   = 1'b1;
      drive_beat(16'h00AA, 0, 1, 32);
      axi_aresetn = 1'b0;
      repeat (3) @(posedge axi_aclk);
      @(negedge axi_aclk);
      checks += 6;
      if (slot_open !== 1'b0) begin failures++; $display("FAIL rst_slot_open: got %b required 0", slot_open); end
      if (s_if.tready !== 1'b0) begin failures++; $display("FAIL rst_s_tready: got %b required 0", s_if.tready); end
      if (m_if.tvalid !== 1'b0) begin failures++; $display("FAIL rst_m_tvalid: got %b required 0", m_if.tvalid); end
      if (stat_pkts_sent !== 32'd0) begin failures++; $display("FAIL rst_sent: got %0d required 0", stat_pkts_sent); end
      if (stat_pkts_deferred !== 32'd0) begin failures++; $display("FAIL rst_deferred: got %0d required 0", stat_pkts_deferred); end
      if (stat_overruns !== 32'd0) begin failures++; $display("FAIL rst_overruns: got %0d required 0", stat_overruns); end
      s_if.tvalid = 1'b0;
   endtask

   task automatic test_back_to_back();
      int fc, f0, l0, f1, l1, f2, l2;
      do_reset(1'b0, 100, 10);
      send_pkt(16'h0001, 64, -1, 0, fc, f0, l0);
      send_pkt(16'h0002, 64, -1, 0, fc, f1, l1);
      send_pkt(16'h0003, 64, -1, 0, fc, f2, l2);
      @(negedge axi_aclk);
      checks += 7;
      if (l0 - f0 != 1) begin failures++; $display("FAIL byp_len0: got %0d cycles required 1", l0 - f0); end
      if (l1 - f1 != 1) begin failures++; $display("FAIL byp_len1: got %0d cycles required 1", l1 - f1); end
      if (l2 - f2 != 1) begin failures++; $display("FAIL byp_len2: got %0d cycles required 1", l2 - f2); end
      if (f1 - l0 != 2) begin failures++; $display("FAIL byp_gap01: got %0d required 2", f1 - l0); end
      if (f2 - l1 != 2) begin failures++; $display("FAIL byp_gap12: got %0d required 2", f2 - l1); end
      if (stat_pkts_sent !== 32'd3) begin failures++; $display("FAIL byp_sent: got %0d required 3", stat_pkts_sent); end
      if (stat_pkts_deferred !== 32'd0) begin failures++; $display("FAIL byp_deferred: got %0d required 0", stat_pkts_deferred); end
   endtask

   task automatic test_guard();
      int fc, fy, ly;
      do_reset(1'b1, 100, 10);
      send_pkt(16'h0010, 64, -1, 0, fc, fy, ly);
      @(negedge axi_aclk);
      checks += 3;
      if (fc != 11) begin failures++; $display("FAIL guard_first_count: got %0d required 11", fc); end
      if (stat_pkts_deferred !== 32'd1) begin failures++; $display("FAIL guard_deferred: got %0d required 1", stat_pkts_deferred); end
      if (stat_pkts_sent !== 32'd1) begin failures++; $display("FAIL guard_sent: got %0d required 1", stat_pkts_sent); end
   endtask

   task automatic test_slot_end();
      int fc, fy, ly;
      do_reset(1'b1, 100, 10);
      wait_count(98);
      send_pkt(16'h0020, 64, -1, 0, fc, fy, ly);
      checks++;
      if (fc != 11) begin failures++; $display("FAIL end64_first_count: got %0d required 11", fc); end
      wait_count(98);
      send_pkt(16'h0021, 32, -1, 0, fc, fy, ly);
      @(negedge axi_aclk);
      checks += 3;
      if (fc != 99) begin failures++; $display("FAIL end32_first_count: got %0d required 99", fc); end
      if (stat_pkts_deferred !== 32'd1) begin failures++; $display("FAIL end_deferred: got %0d required 1", stat_pkts_deferred); end
      if (stat_pkts_sent !== 32'd2) begin failures++; $display("FAIL end_sent: got %0d required 2", stat_pkts_sent); end
   endtask

   task automatic test_overrun();
      int fc, fy, ly;
      do_reset(1'b1, 20, 2);
      wait_count(2);
      send_pkt(16'h0030, 256, 3, 15, fc, fy, ly);
      @(negedge axi_aclk);
      checks += 5;
      if (fc != 3) begin failures++; $display("FAIL ovr_first_count: got %0d required 3", fc); end
      if (ly - fy != 22) begin failures++; $display("FAIL ovr_duration: got %0d required 22", ly - fy); end
      if (stat_overruns !== 32'd1) begin failures++; $display("FAIL ovr_overruns: got %0d required 1", stat_overruns); end
      if (stat_pkts_sent !== 32'd1) begin failures++; $display("FAIL ovr_sent: got %0d required 1", stat_pkts_sent); end
      if (stat_pkts_deferred !== 32'd0) begin failures++; $display("FAIL ovr_deferred: got %0d required 0", stat_pkts_deferred); end
   endtask

   task automatic test_degenerate();
      int lens[2]   = '{0, 100};
      int guards[2] = '{0, 100};
      int busy;
      for (int k = 0; k < 2; k++) begin
         do_reset(1'b1, lens[k], guards[k]);
         drive_beat(16'h0050 + 16'(k), 0, 1, 32);
         busy = 0;
         for (int i = 0; i < 500; i++) begin
            @(negedge axi_aclk);
            if (s_if.tready || m_if.tvalid) busy++;
         end
         checks += 3;
         if (busy != 0) begin failures++; $display("FAIL degen%0d_activity: got %0d cycles required 0", k, busy); end
         if (stat_pkts_deferred !== 32'd1) begin failures++; $display("FAIL degen%0d_deferred: got %0d required 1", k, stat_pkts_deferred); end
         if (stat_pkts_sent !== 32'd0) begin failures++; $display("FAIL degen%0d_sent: got %0d required 0", k, stat_pkts_sent); end
         @(posedge axi_aclk); #1;
         s_if.tvalid = 1'b0;
      end
   endtask

   task automatic test_reset_mid();
      int fc, fy, ly, got;
      do_reset(1'b0, 100, 0);
      send_pkt(16'h0040, 32, -1, 0, fc, fy, ly);
      @(negedge axi_aclk);
      checks++;
      if (stat_pkts_sent !== 32'd1) begin failures++; $display("FAIL mid_pre_sent: got %0d required 1", stat_pkts_sent); end
      @(posedge axi_aclk); #1;
      got = 0;
      drive_beat(16'h0041, 0, 8, 256);
      for (int i = 0; i < 50 && got < 2; i++) begin
         @(negedge axi_aclk);
         if (m_if.tvalid && m_if.tready) got++;
         @(posedge axi_aclk); #1;
         drive_beat(16'h0041, got, 8, 256);
      end
      if (got < 2) begin
         checks++;
         failures++;
         $display("FAIL mid_start_timeout: beats=%0d required 2", got);
      end
      axi_aresetn = 1'b0;
      #1;
      checks += 4;
      if (s_if.tready !== 1'b0) begin failures++; $display("FAIL mid_s_tready: got %b required 0", s_if.tready); end
      if (m_if.tvalid !== 1'b0) begin failures++; $display("FAIL mid_m_tvalid: got %b required 0", m_if.tvalid); end
      if (slot_open !== 1'b0) begin failures++; $display("FAIL mid_slot_open: got %b required 0", slot_open); end
      if (stat_pkts_sent !== 32'd0) begin failures++; $display("FAIL mid_rst_sent: got %0d required 0", stat_pkts_sent); end
      do_reset(1'b0, 100, 0);
      send_pkt(16'h0042, 32, -1, 0, fc, fy, ly);
      @(negedge axi_aclk);
      checks += 3;
      if (stat_pkts_sent !== 32'd1) begin failures++; $display("FAIL mid_post_sent: got %0d required 1", stat_pkts_sent); end
      if (stat_pkts_deferred !== 32'd0) begin failures++; $display("FAIL mid_post_deferred: got %0d required 0", stat_pkts_deferred); end
      if (stat_overruns !== 32'd0) begin failures++; $display("FAIL mid_post_overruns: got %0d required 0", stat_overruns); end
   endtask

   initial begin
      s_if.tdata  = '0;
      s_if.tstrb  = '0;
      s_if.tuser  = '0;
      s_if.tvalid = 1'b0;
      s_if.tlast  = 1'b0;
      m_if.tready = 1'b1;
      test_reset();
      test_back_to_back();
      test_guard();
      test_slot_end();
      test_overrun();
      test_degenerate();
      test_reset_mid();
      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL scoreboard_leftover: got %0d beats required 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
